// File: rtl/mem_bus_arbiter_if.sv
// CPU-side and SRAM-side signals of the memory bus arbiter.
// The arbiter connects through the slave modport; the driving environment uses master.
interface mem_bus_arbiter_if;

   logic        rom_ce_i;
   logic [31:0] rom_addr_i;
   logic [31:0] rom_data_o;
   logic        ram_ce_i;
   logic        ram_we_i;
   logic [31:0] ram_addr_i;
   logic [31:0] ram_data_i;
   logic [3:0]  ram_sel_i;
   logic [31:0] ram_data_o;
   logic        stallreq_o;
   logic        sram_req_o;
   logic        sram_we_o;
   logic [31:0] sram_addr_o;
   logic [31:0] sram_wdata_o;
   logic [3:0]  sram_sel_o;
   logic [31:0] sram_rdata_i;
   logic        sram_ack_i;
   logic        bus_err_o;

   modport slave (
      input  rom_ce_i, rom_addr_i, ram_ce_i, ram_we_i, ram_addr_i, ram_data_i, ram_sel_i,
             sram_rdata_i, sram_ack_i,
      output rom_data_o, ram_data_o, stallreq_o, sram_req_o, sram_we_o, sram_addr_o,
             sram_wdata_o, sram_sel_o, bus_err_o
   );

   modport master (
      output rom_ce_i, rom_addr_i, ram_ce_i, ram_we_i, ram_addr_i, ram_data_i, ram_sel_i,
             sram_rdata_i, sram_ack_i,
      input  rom_data_o, ram_data_o, stallreq_o, sram_req_o, sram_we_o, sram_addr_o,
             sram_wdata_o, sram_sel_o, bus_err_o
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Serialises CPU fetch (rom) and data (ram) accesses onto one single-port SRAM.
// Define ARB_TIMEOUT_EN to abort an access after TIMEOUT cycles without ack.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   mem_bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BUSY_MEM, BUSY_IF} state_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      logic [31:0] rom_data;
      logic [31:0] ram_data;
      logic        if_done;
      logic        mem_done;
   } regs_t;

   state_t state_q, state_d;
   regs_t  r_q, r_d;
   logic   stall;

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_bus_arbiter: TIMEOUT must be in 1..255");
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
   logic [7:0] cnt_q, cnt_d;
   logic       bus_err_q, bus_err_d;
`endif

   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
      stall   = (bus.rom_ce_i & ~r_q.if_done) | (bus.ram_ce_i & ~r_q.mem_done);
      state_d = state_q;
      r_d     = r_q;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      bus_err_d = 1'b0;
`endif
      // The pipeline advances in any cycle without a stall; that retires both results.
      if (!stall) begin
         r_d.if_done  = 1'b0;
         r_d.mem_done = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.ram_ce_i && !r_q.mem_done) begin
               state_d   = BUSY_MEM;
               r_d.req   = 1'b1;
               r_d.we    = bus.ram_we_i;
               r_d.addr  = bus.ram_addr_i;
               r_d.wdata = bus.ram_data_i;
               r_d.sel   = bus.ram_sel_i;
            end else if (bus.rom_ce_i && !r_q.if_done) begin
               state_d  = BUSY_IF;
               r_d.req  = 1'b1;
               r_d.we   = 1'b0;
               r_d.addr = bus.rom_addr_i;
               r_d.sel  = 4'b1111;
            end
         end

         BUSY_MEM, BUSY_IF: begin
            if (bus.sram_ack_i) begin
               state_d = IDLE;
               r_d.req = 1'b0;
               if (state_q == BUSY_MEM) begin
                  r_d.mem_done = 1'b1;
                  if (!r_q.we) r_d.ram_data = bus.sram_rdata_i;
               end else begin
                  r_d.if_done  = 1'b1;
                  r_d.rom_data = bus.sram_rdata_i;
               end
`ifdef ARB_TIMEOUT_EN
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               r_d.req   = 1'b0;
               cnt_d     = '0;
               bus_err_d = 1'b1;
               if (state_q == BUSY_MEM) begin
                  r_d.mem_done = 1'b1;
                  r_d.ram_data = 32'h0;
               end else begin
                  r_d.if_done  = 1'b1;
                  r_d.rom_data = 32'h0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`else
            end
`endif
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         r_q     <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus.bus_err_o = bus_err_q;
`else
   assign bus.bus_err_o = 1'b0;
`endif

   assign bus.stallreq_o   = stall;
   assign bus.sram_req_o   = r_q.req;
   assign bus.sram_we_o    = r_q.we;
   assign bus.sram_addr_o  = r_q.addr;
   assign bus.sram_wdata_o = r_q.wdata;
   assign bus.sram_sel_o   = r_q.sel;
   assign bus.rom_data_o   = r_q.rom_data;
   assign bus.ram_data_o   = r_q.ram_data;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port SRAM between the CPU instruction-fetch port (rom_*) and the data port (ram_*).
- Sits between cpu and the memory wrapper. Serialises the two requests and raises a stall request to ctrl until both are served.
- Served data is held in registers, so the pipeline sees both results in the release cycle.

Parameters:
- TIMEOUT, 255, max cycles to wait for sram_ack_i before aborting (1..255; counter is 8 bits).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- rom_ce_i  in  1  fetch request enable
- rom_addr_i  in  32  fetch address
- rom_data_o  out  32  fetched instruction (held)
- ram_ce_i  in  1  data access enable
- ram_we_i  in  1  1 = write, 0 = read
- ram_addr_i  in  32  data address
- ram_data_i  in  32  write data
- ram_sel_i  in  4  byte enables
- ram_data_o  out  32  read data (held)
- stallreq_o  out  1  stall request to ctrl
- sram_req_o  out  1  SRAM request, held until ack
- sram_we_o  out  1  SRAM write
- sram_addr_o  out  32  SRAM address
- sram_wdata_o  out  32  SRAM write data
- sram_sel_o  out  4  SRAM byte enables
- sram_rdata_i  in  32  SRAM read data, valid with ack
- sram_ack_i  in  1  one-cycle completion pulse
- bus_err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - sram_req_o, sram_we_o, bus_err_o = 0.
  - sram_addr_o, sram_wdata_o = 0; sram_sel_o = 4'b0000.
  - rom_data_o, ram_data_o = 0.
  - Done flags if_done and mem_done = 0; timeout counter = 0.
  - Reset mid-transaction abandons the access silently: no bus_err, no data update.
- CPU-side contract:
  - All rom_*/ram_* inputs stay stable while stallreq_o=1.
  - A cycle with stallreq_o=0 is the pipeline-advance cycle. Both done flags clear at the following edge.
- stallreq_o is combinational: (rom_ce_i & ~if_done) | (ram_ce_i & ~mem_done).
  - With both ce=0, stallreq_o=0.
  - Minimum cost of any access is request latency + 1 cycle.
- FSM:
  - IDLE:
    - ram_ce_i & ~mem_done → BUSY_MEM. Register sram_req_o=1, sram_we_o=ram_we_i, addr/wdata/sel from the ram_* inputs.
    - Else rom_ce_i & ~if_done → BUSY_IF. Register sram_req_o=1, sram_we_o=0, sel=4'b1111, addr=rom_addr_i.
    - The data port always wins: it is the older instruction.
  - BUSY_MEM / BUSY_IF:
    - sram_req_o and all sram_* outputs held constant; counter increments each cycle.
    - On sram_ack_i: drop req and clear the counter.
    - For a read, capture sram_rdata_i into ram_data_o or rom_data_o. A write leaves ram_data_o unchanged.
    - Set the matching done flag and return to IDLE.
  - The earliest ack is one cycle after req rises. sram_ack_i in IDLE is ignored.
- Holding registers keep their value until the next capture.
- Back-to-back: after IDLE→BUSY_MEM→IDLE, the IF request issues from IDLE the next cycle (one dead cycle, by design).
- Port not enabled (ce=0) is never issued, and its done flag stays 0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - If the counter reaches TIMEOUT in a BUSY state without ack, drop req and load 32'h0 into that port's data register.
  - Set its done flag, pulse bus_err_o for one cycle, return to IDLE.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- Undefined:
  - No timeout; the arbiter waits indefinitely.
  - bus_err_o is constant 0; the counter logic is removed.

Test Plan:
- Fetch only:
  - Stimulus: rom_ce=1, addr=0x100, ack 2 cycles after req with rdata=0x3C010001.
  - Response: req high 3 cycles, sram_addr=0x100, sel=1111. rom_data_o=0x3C010001 and stallreq drops the cycle after ack.
- Simultaneous read:
  - Stimulus: rom_ce=1 (0x104), ram_ce=1 read 0x2000, immediate acks with data 0xAAAA5555 then 0x12345678.
  - Response: SRAM sees 0x2000 first, then 0x104. ram_data_o=0xAAAA5555, rom_data_o=0x12345678, stallreq low only after both.
- Byte write:
  - Stimulus: ram_we=1, sel=0011, addr 0x2004, data 0xDEADBEEF.
  - Response: sram_we=1, sel=0011, wdata=0xDEADBEEF. ram_data_o unchanged.
- Reset mid-op:
  - Stimulus: rst=0 while in BUSY_MEM, ack arrives afterwards.
  - Response: the next cycle shows req=0, state IDLE, data registers 0, bus_err=0. The late ack is ignored.
- Stray ack:
  - Stimulus: sram_ack_i=1 with both ce=0.
  - Response: no output changes, stallreq=0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=4):
  - Stimulus: no ack on a fetch.
  - Response: bus_err pulses once after 4 req cycles, rom_data_o=0, stallreq releases.
